// File: rtl/ah_ddr2pl_pkg.sv
// ah_ddr2pl_pkg: shared FSM state, AXI constants and burst sizing for the DDR-to-PL read engine
package ah_ddr2pl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DATA, S_DRAIN, S_FINISH} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  // Largest burst that fits the word budget, the configured maximum and the current 4 KB page.
  function automatic logic [31:0] calc_blen(input logic [31:0] remaining, input logic [11:0] addr_lo,
                                            input int unsigned burst_len);
    logic [31:0] to_4k;
    logic [31:0] b;
    to_4k = (32'd4096 - {20'd0, addr_lo}) >> 2;
    b = burst_len;
    b = remaining < b ? remaining : b;
    return to_4k < b ? to_4k : b;
  endfunction
endpackage

// File: rtl/ah_ddr2pl_fifo.sv
// ah_ddr2pl_fifo: synchronous show-ahead FIFO with occupancy count
module ah_ddr2pl_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/ah_ddr2pl_read_engine.sv
// ah_ddr2pl_read_engine: AXI4 INCR-burst DDR reader streaming words to PL over valid/ready.
// Optional AH_DDR2PL_PERF_CNT_EN adds a saturating stall_cycles counter output.
module ah_ddr2pl_read_engine
  import ah_ddr2pl_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int BURST_LEN = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ddr_addr_start,
  input  logic [31:0]                   num_words,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [31:0]                   words_read,
`ifdef AH_DDR2PL_PERF_CNT_EN
  output logic [31:0]                   stall_cycles,
`endif
  output logic [C_M_AXI_DATA_WIDTH-1:0] data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
  logic [31:0] remaining, blen, free;
  logic [8:0] beats;
  logic [CW-1:0] fifo_count;
  logic fifo_empty, r_hs, beat_err, last_beat;
  assign m_axi_arsize = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign data_valid = !fifo_empty;
  assign r_hs = m_axi_rvalid && m_axi_rready;
  assign last_beat = beats == 9'd1;
  assign beat_err = (m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_beat);
  assign blen = calc_blen(remaining, addr[11:0], BURST_LEN);
  assign free = 32'(FIFO_DEPTH) - 32'(fifo_count);
  ah_ddr2pl_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(C_M_AXI_DATA_WIDTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(r_hs),
    .din(m_axi_rdata),
    .pop(data_valid && data_ready),
    .dout(data_out),
    .count(fifo_count),
    .empty(fifo_empty)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      addr <= '0;
      remaining <= '0;
      beats <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      words_read <= '0;
      m_axi_araddr <= '0;
      m_axi_arlen <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_hs) begin
        words_read <= words_read + 32'd1;
        beats <= beats - 9'd1;
        if (beat_err) error <= 1'b1;
      end
      case (state)
        S_IDLE: if (start) begin
          addr <= ddr_addr_start & ~C_M_AXI_ADDR_WIDTH'(3);
          remaining <= num_words;
          words_read <= '0;
          error <= 1'b0;
          busy <= 1'b1;
          done <= num_words == '0;
          state <= num_words == '0 ? S_FINISH : S_ISSUE;
        end
        // Space for the whole burst is reserved before AR goes out, so R never stalls.
        S_ISSUE: if (!m_axi_arvalid) begin
          if (free >= blen) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr <= addr;
            m_axi_arlen <= 8'(blen - 32'd1);
          end
        end else if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          addr <= addr + C_M_AXI_ADDR_WIDTH'(blen << 2);
          remaining <= remaining - blen;
          beats <= 9'(blen);
          m_axi_rready <= 1'b1;
          state <= S_DATA;
        end
        S_DATA: if (r_hs && last_beat) begin
          m_axi_rready <= 1'b0;
          state <= (remaining != '0 && !error && !beat_err) ? S_ISSUE : S_DRAIN;
        end
        S_DRAIN: if (fifo_empty) begin
          done <= 1'b1;
          state <= S_FINISH;
        end
        S_FINISH: begin
          busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef AH_DDR2PL_PERF_CNT_EN
  logic [1:0] stall_inc;
  logic [32:0] stall_sum;
  assign stall_inc = {1'b0, busy && data_valid && !data_ready} + {1'b0, m_axi_arvalid && !m_axi_arready};
  assign stall_sum = {1'b0, stall_cycles} + 33'(stall_inc);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles <= '0;
    else if (state == S_IDLE && start) stall_cycles <= '0;
    else stall_cycles <= stall_sum[32] ? '1 : stall_sum[31:0];
  end
`endif
endmodule

// File: tb/tb_ah_ddr2pl_read_engine.sv
// tb_ah_ddr2pl_read_engine: job table plus random jobs against a burst/word-list reference model
module tb_ah_ddr2pl_read_engine;
  localparam int TB_BURST = 16;
  localparam int TB_DEPTH = 64;
  logic clk = 1'b0, rst;
  logic start, busy, done, error, data_valid, data_ready;
  logic [31:0] ddr_addr_start, num_words, words_read, data_out, m_axi_araddr, m_axi_rdata;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst, m_axi_rresp;
  logic m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  always #5 clk = ~clk;
  ah_ddr2pl_read_engine #(.BURST_LEN(TB_BURST), .FIFO_DEPTH(TB_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .ddr_addr_start(ddr_addr_start), .num_words(num_words),
    .busy(busy), .done(done), .error(error), .words_read(words_read),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );
  typedef struct {
    logic [31:0] addr;
    int n;
    int mode;
    int eb;
    int ebeat;
    int exp_words;
    bit exp_err;
  } job_t;
  job_t jobs[6];
  int checks = 0, failures = 0;
  logic [31:0] salt;
  logic [31:0] ar_addr_q[$], exp_data[$];
  int ar_len_q[$];
  bit bur_act, jitter;
  logic [31:0] bur_addr;
  int bur_len, bur_beat, bursts_seen, err_burst, err_beat;
  int accepted, popped, done_cnt, done_cyc, cyc, ready_mode, hold_cycles;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ salt ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_error"}, error, 0);
    check({p, "_words"}, words_read, 0);
    check({p, "_dvalid"}, data_valid, 0);
    check({p, "_arvalid"}, m_axi_arvalid, 0);
    check({p, "_rready"}, m_axi_rready, 0);
    check({p, "_araddr"}, m_axi_araddr, 0);
    check({p, "_arlen"}, m_axi_arlen, 0);
  endtask

  // Called at a falling edge: decides bench inputs for the next rising edge and
  // accounts for the handshakes that edge will complete (DUT outputs are registered).
  task automatic step();
    data_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ($urandom % 3 != 0) : (cyc >= hold_cycles);
    if (ready_mode == 2 && cyc == hold_cycles - 1) begin
      check("bp_words_read", words_read, TB_DEPTH);
      check("bp_buffered", accepted - popped, TB_DEPTH);
    end
    if (data_valid && data_ready) begin
      popped++;
      if (exp_data.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL data_extra: got %h want none", data_out);
      end else check("data", data_out, exp_data.pop_front());
    end
    if (bur_act) begin
      m_axi_rvalid = !jitter || ($urandom % 4 != 0);
      m_axi_rdata = mem_word(bur_addr + 32'(4 * bur_beat));
      m_axi_rlast = bur_beat == bur_len - 1;
      m_axi_rresp = (bursts_seen == err_burst && bur_beat == err_beat - 1) ? 2'b10 : 2'b00;
      if (m_axi_rvalid && m_axi_rready) begin
        accepted++;
        bur_beat++;
        if (bur_beat == bur_len) bur_act = 0;
      end
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rlast = 1'b0;
      m_axi_rresp = 2'b00;
    end
    m_axi_arready = !jitter || ($urandom % 2 == 0);
    if (m_axi_arvalid && m_axi_arready) begin
      bursts_seen++;
      if (ar_addr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ar_extra: got addr %h len %0d want no burst", m_axi_araddr, m_axi_arlen);
      end else begin
        check("ar_addr", m_axi_araddr, ar_addr_q.pop_front());
        check("ar_len", m_axi_arlen, ar_len_q.pop_front());
      end
      check("ar_space", (accepted - popped + m_axi_arlen + 1) <= TB_DEPTH, 1);
      check("ar_size_burst", {m_axi_arsize, m_axi_arburst}, 5'b010_01);
      bur_act = 1;
      bur_addr = m_axi_araddr;
      bur_len = m_axi_arlen + 1;
      bur_beat = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_job(input logic [31:0] addr, input int n, input int mode, input int eb,
                         input int ebeat, input int exp_words, input bit exp_err, input int abort);
    logic [31:0] a;
    int rem, bl, idx, total;
    salt = $urandom;
    ar_addr_q.delete();
    ar_len_q.delete();
    exp_data.delete();
    bur_act = 0;
    bursts_seen = 0;
    err_burst = eb;
    err_beat = ebeat;
    accepted = 0;
    popped = 0;
    done_cnt = 0;
    done_cyc = -1;
    cyc = 0;
    ready_mode = mode;
    hold_cycles = 150;
    jitter = mode == 1;
    a = addr & ~32'd3;
    rem = n;
    idx = 1;
    total = 0;
    while (rem > 0) begin
      bl = TB_BURST;
      if (rem < bl) bl = rem;
      if ((4096 - int'(a[11:0])) / 4 < bl) bl = (4096 - int'(a[11:0])) / 4;
      ar_addr_q.push_back(a);
      ar_len_q.push_back(bl - 1);
      for (int i = 0; i < bl; i++) exp_data.push_back(mem_word(a + 32'(4 * i)));
      total += bl;
      a += 32'(4 * bl);
      rem -= bl;
      if (idx == eb) break;
      idx++;
    end
    start = 1'b1;
    ddr_addr_start = addr;
    num_words = n;
    step();
    start = 1'b0;
    ddr_addr_start = $urandom;
    num_words = $urandom;
    check("busy_after_start", busy, 1);
    check("err_cleared", error, 0);
    while (done_cnt == 0 && cyc < 5000 && !(abort >= 0 && accepted >= abort)) step();
    if (abort >= 0) return;
    check("done_pulse_len", done, 0);
    check("busy_end", busy, 0);
    step();
    step();
    check("done_once", done_cnt, 1);
    check("words_read", words_read, exp_words < 0 ? total : exp_words);
    check("error", error, exp_err);
    check("data_left", exp_data.size(), 0);
    check("ar_left", ar_addr_q.size(), 0);
    if (n == 0) check("zero_done_cyc", done_cyc, 1);
  endtask

  initial begin
    jobs[0] = '{32'h0010_0000, 40, 0, 0, 0, 40, 1'b0};
    jobs[1] = '{32'h0010_0FF0, 16, 0, 0, 0, 16, 1'b0};
    jobs[2] = '{32'h0000_4000, 0, 0, 0, 0, 0, 1'b0};
    jobs[3] = '{32'h0030_0000, 200, 2, 0, 0, 200, 1'b0};
    jobs[4] = '{32'h0020_0000, 48, 0, 1, 5, 16, 1'b1};
    jobs[5] = '{32'h0010_0FE3, 37, 1, 0, 0, 37, 1'b0};
    rst = 1'b1;
    start = 1'b0;
    ddr_addr_start = '0;
    num_words = '0;
    data_ready = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rdata = '0;
    m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0;
    m_axi_rvalid = 1'b0;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      run_job(jobs[i].addr, jobs[i].n, jobs[i].mode, jobs[i].eb, jobs[i].ebeat, jobs[i].exp_words, jobs[i].exp_err, -1);
    for (int i = 0; i < 6; i++)
      run_job($urandom & 32'h0FFF_FFFF, $urandom_range(1, 100), 1, 0, 0, -1, 1'b0, -1);
    run_job(32'h0040_0000, 64, 0, 0, 0, 64, 1'b0, 5);
    check("rready_before_rst", m_axi_rready, 1);
    #2 rst = 1'b1;
    #1 check_reset("async_rst");
    @(negedge clk);
    rst = 1'b0;
    bur_act = 0;
    m_axi_rvalid = 1'b0;
    m_axi_arready = 1'b0;
    data_ready = 1'b0;
    run_job(32'h0050_0000, 16, 0, 0, 0, 16, 1'b0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ah_ddr2pl_read_engine.md
Name: ah_ddr2pl_read_engine

Overview:
AXI4 full master read engine: the read-back counterpart of the PL2DDR writer.
- On a start command, fetches a word-counted region of DDR using INCR bursts.
- Buffers the returned beats in an internal FIFO and streams them to PL logic over a valid/ready interface.
- Sits between the PS HP/ACP port and PL consumers, such as replay or verification of captured samples.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width.
C_M_AXI_DATA_WIDTH, 32, AXI/stream data width; only 32 supported.
BURST_LEN, 16, maximum beats per burst (1..256, power of 2).
FIFO_DEPTH, 64, FIFO entries; power of 2, >= 2*BURST_LEN.

Ports:
clk  in  1  system clock for all logic.
rst  in  1  asynchronous active-high reset.
start  in  1  one-cycle request to begin a read job.
ddr_addr_start  in  32  byte start address; bits[1:0] ignored (treated as 0).
num_words  in  32  number of 32-bit words to read.
busy  out  1  job in progress.
done  out  1  one-cycle pulse at job end.
error  out  1  sticky until the next accepted start.
words_read  out  32  beats accepted from the R channel in the current job.
data_out  out  32  stream data.
data_valid  out  1  stream valid.
data_ready  in  1  stream ready.
m_axi_araddr  out  32  AR address.
m_axi_arlen  out  8  AR burst length - 1.
m_axi_arsize  out  3  constant 3'b010.
m_axi_arburst  out  2  constant 2'b01 (INCR).
m_axi_arvalid  out  1  AR valid.
m_axi_arready  in  1  AR ready.
m_axi_rdata  in  32  R data.
m_axi_rresp  in  2  R response.
m_axi_rlast  in  1  R last.
m_axi_rvalid  in  1  R valid.
m_axi_rready  out  1  R ready.

Behaviour:
- Reset (async assert, sync release) clears all of the following:
  - Outputs: busy=0, done=0, error=0, words_read=0, data_valid=0, arvalid=0, rready=0, araddr=0, arlen=0.
  - FIFO is empty; FSM goes to IDLE.
- FSM states: IDLE, ISSUE, DATA, DRAIN, FINISH.
- IDLE:
  - start=1 latches addr = {ddr_addr_start[31:2],2'b00}, remaining = num_words, clears words_read and error, sets busy=1, then goes to ISSUE.
  - If num_words=0, goes directly to FINISH instead; no AXI traffic.
- Start handling outside IDLE: start is ignored.
- ISSUE:
  - Burst length is blen = min(BURST_LEN, remaining, (4096 - addr[11:0])/4); a burst never crosses a 4 KB boundary.
  - arvalid is asserted only when FIFO free entries >= blen. arlen = blen-1 and araddr = addr are registered and held stable while arvalid=1.
  - On arvalid&&arready: addr += blen*4, remaining -= blen, beat counter = blen, then go to DATA.
- DATA:
  - rready=1; space for these beats is already reserved.
  - Each rvalid&&rready writes rdata to the FIFO, increments words_read and decrements the beat counter.
  - rresp != 2'b00 sets error.
  - rlast on a beat whose counter != 1, or no rlast on the beat whose counter == 1, sets error.
  - After the last beat: go to ISSUE if remaining>0 and error=0; otherwise go to DRAIN.
  - Only one burst is outstanding at a time.
- DRAIN: wait for the FIFO to be empty, then go to FINISH.
- FINISH: pulse done for 1 cycle, busy=0, return to IDLE.
- Errors: an error stops further AR issue, but the current burst is always completed on the bus. Data already buffered is still streamed out.
- FIFO:
  - Show-ahead: data_valid = !empty, and data_out is the head entry.
  - A pop occurs on data_valid&&data_ready; a push and pop in the same cycle is legal when the FIFO is full.
  - Latency from R handshake to data_valid: 1 cycle.
- Counters: words_read is 32 bits and wraps modulo 2^32; remaining never underflows because blen <= remaining.
- Reset mid-job: state is abandoned immediately. The system must reset the interconnect in the same event.

Optional Feature:
AH_DDR2PL_PERF_CNT_EN
- Defined: adds output stall_cycles[31:0], cleared on start. It counts cycles with busy&&data_valid&&!data_ready (consumer backpressure) plus cycles with arvalid&&!arready (bus backpressure). It saturates at 32'hFFFFFFFF.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package ah_ddr2pl_pkg holds:
  - FSM state enum.
  - Constants AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_RESP_OKAY=2'b00.
  - Function calc_blen(remaining, addr, BURST_LEN).
- Sub-module ah_ddr2pl_fifo: synchronous show-ahead FIFO with count output, parameterised by depth and width.

Test Plan:
- start, addr=0x00100000, num_words=40, BURST_LEN=16, data_ready=1 -> bursts of arlen 15, 15, 7 at 0x00100000, 0x00100040, 0x00100080; 40 words in order; words_read=40; done pulses once; error=0.
- addr=0x00100FF0, num_words=16 -> first burst arlen=3 at 0x00100FF0, second arlen=11 at 0x00101000.
- num_words=0 -> done pulses 1 cycle after start, no arvalid, busy high for exactly that job only.
- data_ready=0 with num_words=200, FIFO_DEPTH=64 -> at most 64 words buffered; arvalid held low while free < 16; words_read stops at 64 until data_ready=1, then job completes with 200 words.
- rresp=2'b10 on beat 5 of burst 1 of 48 words -> burst completes, no further AR; error=1; 16 words streamed; done pulses; next start clears error.
- rst asserted mid-DATA -> all outputs return to reset values asynchronously; a new start after release runs a clean 16-word job.
